led32x32_frame_loader: RTL and testbench

LED32X32_FRAME_LOADER -- requirements
Module: led32x32_frame_loader

---
 rtl/led32x32_frame_loader.sv | 166 ++++++++++++++++
 tb/tb_led32x32_frame_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led32x32_frame_loader.sv
// led32x32_frame_loader
// Receives a 128-byte frame (32 rows x 4 bytes, MSB-first) on a byte stream
// and writes it to a BRAM frame slot one 32-bit row at a time. The stream is
// stalled while the downstream row streamer is reading the slot being loaded.
// A frame is committed only when exactly 128 bytes arrive and s_last marks
// the final byte. Any other termination raises err. Rows that were already
// written stay in BRAM, but they are not committed.
module led32x32_frame_loader #(
  parameter int unsigned FRAME_SEL_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [FRAME_SEL_WIDTH-1:0] frame_sel,
  input  logic                       s_valid,
  input  logic [7:0]                 s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  input  logic                       disp_busy,
  input  logic [FRAME_SEL_WIDTH-1:0] disp_frame_sel,
  output logic                       bram_wr_en,
  output logic [FRAME_SEL_WIDTH+4:0] bram_wr_addr,
  output logic [31:0]                bram_wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [FRAME_SEL_WIDTH-1:0] committed_frame,
  output logic                       frame_valid
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t                     state;
  state_t                     state_next;

  logic [FRAME_SEL_WIDTH-1:0] cur_frame;
  logic [6:0]                 byte_cnt;
  logic [23:0]                holding;

  // Decoded control for the current cycle.
  logic                       stall;
  logic                       start_load;
  logic                       accept;
  logic                       final_byte;
  logic                       finish_ok;
  logic                       finish_err;
  logic                       row_write;

  // The slot being loaded is locked while the display is reading that slot.
  always_comb begin
    stall = disp_busy && (disp_frame_sel == cur_frame);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, stream handshake and decode of the terminating byte.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    start_load = 1'b0;
    accept     = 1'b0;
    final_byte = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    row_write  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_load = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        s_ready = !stall;
        accept  = s_valid && !stall;
        if (accept) begin
          final_byte = (byte_cnt == 7'd127);
          // A frame ends either on s_last or on byte 127. Only both together
          // form a good frame. The row that an erroring byte would complete
          // is dropped.
          if (s_last || final_byte) begin
            state_next = S_IDLE;
            if (s_last && final_byte) begin
              finish_ok = 1'b1;
            end else begin
              finish_err = 1'b1;
            end
          end
          row_write = (byte_cnt[1:0] == 2'b11) && !finish_err;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Byte counter, holding shift register and target slot for the active load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_frame <= '0;
      byte_cnt  <= '0;
      holding   <= '0;
    end else begin
      if (start_load) begin
        cur_frame <= frame_sel;
        byte_cnt  <= '0;
      end
      if (accept) begin
        holding  <= {holding[15:0], s_data};
        byte_cnt <= byte_cnt + 7'd1;
      end
    end
  end

  // BRAM row write port: the strobe is a single cycle, and addr/data are held
  // between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= '0;
    end else begin
      bram_wr_en <= row_write;
      if (row_write) begin
        bram_wr_addr <= {cur_frame, byte_cnt[6:2]};
        bram_wr_data <= {holding, s_data};
      end
    end
  end

  // Status: busy spans the load, done and err are single-cycle pulses, and
  // the commit is updated only by a good frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      committed_frame <= '0;
      frame_valid     <= 1'b0;
    end else begin
      done <= finish_ok;
      err  <= finish_err;
      if (start_load) begin
        busy <= 1'b1;
      end else if (finish_ok || finish_err) begin
        busy <= 1'b0;
      end
      if (finish_ok) begin
        committed_frame <= cur_frame;
        frame_valid     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led32x32_frame_loader.sv
// Testbench for led32x32_frame_loader. A frame-level reference model keeps
// the received bytes in a queue and checks the DUT outputs on every cycle.
// Literal checks after each scenario pin the model's expectations.
`timescale 1ns/1ps
module tb_led32x32_frame_loader;

  localparam int FSW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [FSW-1:0] frame_sel;
  logic           s_valid;
  logic [7:0]     s_data;
  logic           s_last;
  logic           s_ready;
  logic           disp_busy;
  logic [FSW-1:0] disp_frame_sel;
  logic           bram_wr_en;
  logic [FSW+4:0] bram_wr_addr;
  logic [31:0]    bram_wr_data;
  logic           busy;
  logic           done;
  logic           err;
  logic [FSW-1:0] committed_frame;
  logic           frame_valid;

  always #5 clk = ~clk;

  led32x32_frame_loader #(.FRAME_SEL_WIDTH(FSW)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_sel(frame_sel),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .disp_busy(disp_busy), .disp_frame_sel(disp_frame_sel),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .busy(busy), .done(done), .err(err),
    .committed_frame(committed_frame), .frame_valid(frame_valid)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit             m_en = 1'b0;
  bit             m_loading = 1'b0;
  logic [FSW-1:0] m_frame = '0;
  byte unsigned   m_q[$];
  bit             m_wr = 1'b0, m_done = 1'b0, m_err = 1'b0, m_busy = 1'b0, m_fv = 1'b0;
  logic [FSW-1:0] m_comm = '0;
  logic [FSW+4:0] m_addr = '0;
  logic [31:0]    m_data = '0;

  function automatic bit m_ready();
    return m_loading && !(disp_busy && (disp_frame_sel == m_frame));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_en = 1'b1; m_loading = 1'b0; m_frame = '0; m_q.delete();
      m_wr = 1'b0; m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_fv = 1'b0;
      m_comm = '0; m_addr = '0; m_data = '0;
    end else begin
      m_wr = 1'b0; m_done = 1'b0; m_err = 1'b0;
      if (!m_loading) begin
        if (start) begin
          m_loading = 1'b1; m_frame = frame_sel; m_q.delete(); m_busy = 1'b1;
        end
      end else if (s_valid && m_ready()) begin : take_byte
        int n;
        m_q.push_back(s_data);
        n = m_q.size();
        if (s_last || n == 128) begin
          m_loading = 1'b0; m_busy = 1'b0;
          if (s_last && n == 128) begin
            m_done = 1'b1; m_comm = m_frame; m_fv = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
        if ((n % 4 == 0) && !m_err) begin
          m_wr   = 1'b1;
          m_addr = {m_frame, 5'(n / 4 - 1)};
          m_data = {m_q[n-4], m_q[n-3], m_q[n-2], m_q[n-1]};
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_en) begin
      chk("s_ready", s_ready, m_ready());
      chk("bram_wr_en", bram_wr_en, m_wr);
      if (m_wr) begin
        chk("bram_wr_addr", bram_wr_addr, m_addr);
        chk("bram_wr_data", bram_wr_data, m_data);
      end
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("committed_frame", committed_frame, m_comm);
      chk("frame_valid", frame_valid, m_fv);
      chk("done_err_exclusive", done && err, 1'b0);
    end
  end

  // ---------------- DUT activity counters ----------------
  int             wr_cnt, done_cnt, err_cnt, busy_cnt, stall_cnt;
  logic [FSW+4:0] first_addr, last_addr;
  logic [31:0]    first_data;

  always @(negedge clk) begin
    if (bram_wr_en === 1'b1) begin
      if (wr_cnt == 0) begin
        first_addr = bram_wr_addr;
        first_data = bram_wr_data;
      end
      last_addr = bram_wr_addr;
      wr_cnt++;
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (busy === 1'b1 && s_ready === 1'b0) stall_cnt++;
  end

  task automatic clear_counters();
    wr_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; stall_cnt = 0;
    first_addr = '0; last_addr = '0; first_data = '0;
  endtask

  task automatic do_start(input logic [FSW-1:0] fs);
    start = 1'b1; frame_sel = fs;
    @(posedge clk); #1;
    start = 1'b0; frame_sel = FSW'($urandom);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Streams up to n bytes. last_idx < 0 means s_last is never set.
  // The stall window is counted in driven cycles. glitch_cyc pulses start
  // with glitch_sel. rst_at asserts reset instead of presenting that byte.
  task automatic send(input int n, input int last_idx, input bit seq, input bit cont,
                      input int st_from, input int st_len, input logic [FSW-1:0] st_sel,
                      input int glitch_cyc, input logic [FSW-1:0] glitch_sel,
                      input int rst_at);
    int i;
    int cyc;
    bit acc;
    i = 0;
    cyc = 0;
    while (i < n) begin
      if (cyc >= 4000) begin
        tests++; fails++;
        $display("FAIL send_timeout: got %0d bytes accepted, expected %0d", i, n);
        break;
      end
      if (i == rst_at) begin
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      s_valid = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
      s_data  = seq ? 8'(i) : 8'($urandom);
      s_last  = (i == last_idx);
      disp_busy      = (cyc >= st_from) && (cyc < st_from + st_len);
      disp_frame_sel = st_sel;
      start          = (cyc == glitch_cyc);
      if (cyc == glitch_cyc) frame_sel = glitch_sel;
      acc = s_valid && m_ready();
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; disp_busy = 1'b0; start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frame_sel = '0; s_valid = 1'b0; s_data = '0;
    s_last = 1'b0; disp_busy = 1'b0; disp_frame_sel = '0;
    clear_counters();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_ready", s_ready, 1'b0);
    chk("reset_wr_en", bram_wr_en, 1'b0);
    chk("reset_wr_addr", bram_wr_addr, 0);
    chk("reset_wr_data", bram_wr_data, 0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_frame_valid", frame_valid, 1'b0);
    chk("reset_committed", committed_frame, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Good frame to slot 2 with bytes 0x00..0x7F and continuous valid.
    clear_counters();
    do_start(3'd2);
    send(128, 127, 1'b1, 1'b1, -1, 0, '0, -1, '0, -1);
    settle();
    chk("f2_writes", wr_cnt, 32);
    chk("f2_first_addr", first_addr, 8'h40);
    chk("f2_first_data", first_data, 32'h00010203);
    chk("f2_last_addr", last_addr, 8'h5F);
    chk("f2_done_cnt", done_cnt, 1);
    chk("f2_err_cnt", err_cnt, 0);
    chk("f2_busy_cycles", busy_cnt, 128);
    chk("f2_committed", committed_frame, 2);
    chk("f2_frame_valid", frame_valid, 1'b1);

    // Slot 1 is read by the display for 10 cycles in the middle of the frame.
    clear_counters();
    do_start(3'd1);
    send(128, 127, 1'b0, 1'b1, 20, 10, 3'd1, -1, '0, -1);
    settle();
    chk("stall_cycles", stall_cnt, 10);
    chk("stall_writes", wr_cnt, 32);
    chk("stall_done", done_cnt, 1);
    chk("stall_committed", committed_frame, 1);

    // The display reads a different slot, so the stream does not stall.
    clear_counters();
    do_start(3'd1);
    send(128, 127, 1'b0, 1'b0, 0, 100000, 3'd3, -1, '0, -1);
    settle();
    chk("nostall_cycles", stall_cnt, 0);
    chk("nostall_done", done_cnt, 1);

    // An early s_last on byte 63 gives an error after rows 0..14.
    clear_counters();
    do_start(3'd4);
    send(64, 63, 1'b0, 1'b0, -1, 0, '0, -1, '0, -1);
    settle();
    chk("early_writes", wr_cnt, 15);
    chk("early_err", err_cnt, 1);
    chk("early_done", done_cnt, 0);
    chk("early_committed", committed_frame, 1);
    chk("early_frame_valid", frame_valid, 1'b1);

    // 128 bytes without s_last give an error and no row-31 write.
    clear_counters();
    do_start(3'd5);
    send(128, -1, 1'b0, 1'b0, -1, 0, '0, -1, '0, -1);
    settle();
    chk("nolast_writes", wr_cnt, 31);
    chk("nolast_err", err_cnt, 1);
    chk("nolast_committed", committed_frame, 1);

    // A start pulse during the load with a different frame_sel is ignored.
    clear_counters();
    do_start(3'd6);
    send(128, 127, 1'b0, 1'b0, -1, 0, '0, 10, 3'd0, -1);
    settle();
    chk("glitch_writes", wr_cnt, 32);
    chk("glitch_first_addr", first_addr, 8'hC0);
    chk("glitch_committed", committed_frame, 6);

    // Reset at byte 70 aborts silently. Slot 3 then reloads cleanly.
    clear_counters();
    do_start(3'd3);
    send(128, 127, 1'b0, 1'b0, -1, 0, '0, -1, '0, 70);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_en", bram_wr_en, 1'b0);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_committed", committed_frame, 0);
    settle();
    chk("rst_writes", wr_cnt, 17);
    chk("rst_done", done_cnt, 0);
    chk("rst_err", err_cnt, 0);
    clear_counters();
    do_start(3'd3);
    send(128, 127, 1'b0, 1'b0, -1, 0, '0, -1, '0, -1);
    settle();
    chk("reload_done", done_cnt, 1);
    chk("reload_writes", wr_cnt, 32);
    chk("reload_committed", committed_frame, 3);

    // Randomized frames with random terminations and display activity.
    for (int k = 0; k < 6; k++) begin : rnd
      int             sel;
      int             last_idx;
      int             nbytes;
      logic [FSW-1:0] fs;
      fs  = FSW'($urandom);
      sel = $urandom_range(0, 2);
      last_idx = (sel == 0) ? 127 : (sel == 1) ? -1 : $urandom_range(0, 126);
      nbytes   = (last_idx >= 0) ? last_idx + 1 : 128;
      do_start(fs);
      send(nbytes, last_idx, 1'b0, 1'b0, $urandom_range(0, 100), $urandom_range(1, 20),
           FSW'($urandom), -1, '0, -1);
      settle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
